// File: rtl/strobe_mem_responder.sv
// Clocked responder for the strobe-driven memory bus: synchronises async read/write
// strobes, commits writes and drives read data on the tri-state bus. Parity via STROBE_MEM_PARITY_EN.
module strobe_mem_responder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    input  logic              read,
    input  logic              write,
    output logic              ack,
    output logic              busy,
`ifdef STROBE_MEM_PARITY_EN
    output logic              perr,
`endif
    output logic              conflict
);

`ifdef STROBE_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ, CONFLICT} state_t;

    state_t              state;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata;
    logic                oe;
    logic [2:0]          rd_sync, wr_sync;
    logic                rd_s2, rd_s3, wr_s2, wr_s3;
    logic [WORD_W-1:0]   wr_word, rd_word;

`ifdef STROBE_MEM_PARITY_EN
    // Stored bit makes the whole word even parity; a set XOR over the word is an error.
    assign wr_word = {^data, data};
`else
    assign wr_word = data;
`endif
    assign rd_word = mem[addr];

    assign rd_s2 = rd_sync[1];
    assign rd_s3 = rd_sync[2];
    assign wr_s2 = wr_sync[1];
    assign wr_s3 = wr_sync[2];

    assign data = oe ? rdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync <= '0;
            wr_sync <= '0;
        end else begin
            rd_sync <= {rd_sync[1:0], read};
            wr_sync <= {wr_sync[1:0], write};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state    <= IDLE;
            ack      <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            oe       <= 1'b0;
            rdata    <= '0;
`ifdef STROBE_MEM_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_s2 && wr_s2) begin
                        state    <= CONFLICT;
                        conflict <= 1'b1;
                        busy     <= 1'b1;
                    end else if (wr_s2 && !wr_s3) begin
                        // Only a rising synchronised strobe commits, so a long strobe writes once.
                        mem[addr] <= wr_word;
                        ack       <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WRITE;
                    end else if (rd_s2 && !rd_s3) begin
                        rdata <= rd_word[DATA_W-1:0];
`ifdef STROBE_MEM_PARITY_EN
                        perr  <= ^rd_word;
`endif
                        oe    <= 1'b1;
                        busy  <= 1'b1;
                        state <= READ;
                    end
                end
                WRITE: begin
                    if (rd_s2) begin
                        state    <= CONFLICT;
                        conflict <= 1'b1;
                    end else if (!wr_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                READ: begin
                    if (wr_s2) begin
                        oe       <= 1'b0;
                        conflict <= 1'b1;
                        state    <= CONFLICT;
                    end else if (!rd_s2) begin
                        oe    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // Reload every cycle so block reads can walk addr with the strobe held.
                        rdata <= rd_word[DATA_W-1:0];
`ifdef STROBE_MEM_PARITY_EN
                        perr  <= ^rd_word;
`endif
                    end
                end
                CONFLICT: begin
                    oe <= 1'b0;
                    if (!rd_s2 && !wr_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_mem_responder.sv
// Scoreboard bench for strobe_mem_responder: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them. Released bus reads as all-ones via the pull-up.
module tb_strobe_mem_responder;

    localparam int K_DATA = 0, K_ACK = 1, K_BUSY = 2, K_CONF = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] addr;
    logic       read, write;
    logic       ack, busy, conflict;
    logic       tb_drv;
    logic [7:0] tb_dout;
    tri1  [7:0] data;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    logic prev_ack = 1'b0;
    exp_t q[$];

    assign data = tb_drv ? tb_dout : 8'hzz;

    strobe_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data(data),
        .read(read), .write(write), .ack(ack), .busy(busy), .conflict(conflict)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int k, input logic [7:0] v);
        exp_t e;
        e.cyc = c; e.kind = k; e.val = v;
        q.push_back(e);
    endtask

    // Monitor: compare every expectation stamped with the current cycle.
    always @(negedge clk) begin
        logic [7:0] got;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                case (q[i].kind)
                    K_DATA:  got = data;
                    K_ACK:   got = {7'd0, ack};
                    K_BUSY:  got = {7'd0, busy};
                    default: got = {7'd0, conflict};
                endcase
                checks++;
                if (got !== q[i].val) begin
                    errors++;
                    $display("FAIL kind%0d cyc=%0d addr=%h got=%h exp=%h",
                             q[i].kind, cyc, addr, got, q[i].val);
                end
                q.delete(i);
            end
        end
        if (ack) begin
            checks++;
            ack_cnt++;
            if (prev_ack) begin
                errors++;
                $display("FAIL ack_width cyc=%0d got=2+ cycles exp=1 cycle", cyc);
            end
        end
        prev_ack = ack;
    end

    task automatic write_word(input logic [4:0] a, input logic [7:0] d, input int hold);
        int t0, t1;
        addr = a; tb_dout = d; tb_drv = 1'b1;
        step(1);
        write = 1'b1; t0 = cyc;
        expect_at(t0 + 3, K_ACK, 8'h01);
        expect_at(t0 + 3, K_BUSY, 8'h01);
        expect_at(t0 + 4, K_ACK, 8'h00);
        step(hold);
        write = 1'b0; t1 = cyc;
        expect_at(t1 + 2, K_BUSY, 8'h01);
        expect_at(t1 + 3, K_BUSY, 8'h00);
        step(4);
        tb_drv = 1'b0;
    endtask

    task automatic read_word(input logic [4:0] a, input logic [7:0] exp);
        int t0, t1;
        tb_drv = 1'b0; addr = a;
        step(1);
        read = 1'b1; t0 = cyc;
        expect_at(t0 + 2, K_DATA, 8'hFF);
        expect_at(t0 + 3, K_DATA, exp);
        step(4);
        read = 1'b0; t1 = cyc;
        expect_at(t1 + 2, K_DATA, exp);
        expect_at(t1 + 3, K_DATA, 8'hFF);
        step(4);
    endtask

    function automatic logic [7:0] pat(input int a);
        return (a % 2 == 0) ? 8'hAA : 8'h55;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, acks0;
        rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0;
        tb_drv = 1'b0; tb_dout = '0;
        expect_at(2, K_ACK, 8'h00);
        expect_at(2, K_BUSY, 8'h00);
        expect_at(2, K_CONF, 8'h00);
        expect_at(2, K_DATA, 8'hFF);
        step(3);
        rst_n = 1'b1;
        step(2);

        // Zero sweep
        acks0 = ack_cnt;
        for (int a = 0; a < 32; a++) write_word(a[4:0], 8'h00, 3);
        checks++;
        if (ack_cnt - acks0 != 32) begin
            errors++;
            $display("FAIL zero_sweep_acks got=%0d exp=32", ack_cnt - acks0);
        end
        read_word(5'h0A, 8'h00);

        // Alternating pattern, then block read 05..09 with read held
        for (int a = 0; a < 32; a++) write_word(a[4:0], pat(a), 3);
        addr = 5'h05;
        step(1);
        read = 1'b1; t0 = cyc;
        expect_at(t0 + 2, K_DATA, 8'hFF);
        expect_at(t0 + 3, K_DATA, 8'h55);
        step(3);
        for (int a = 6; a <= 9; a++) begin
            step(2);
            addr = a[4:0];
            expect_at(cyc, K_DATA, pat(a - 1));
            expect_at(cyc + 1, K_DATA, pat(a));
        end
        step(2);
        read = 1'b0; t1 = cyc;
        expect_at(t1 + 2, K_DATA, 8'h55);
        expect_at(t1 + 3, K_DATA, 8'hFF);
        step(4);

        // Long write strobe: one commit only
        acks0 = ack_cnt;
        write_word(5'h03, 8'h3C, 20);
        checks++;
        if (ack_cnt - acks0 != 1) begin
            errors++;
            $display("FAIL long_write_acks got=%0d exp=1", ack_cnt - acks0);
        end
        read_word(5'h03, 8'h3C);
        read_word(5'h01, 8'h55);

        // Conflict at addr 7 with the bus left floating
        acks0 = ack_cnt;
        tb_drv = 1'b0; addr = 5'h07;
        step(1);
        read = 1'b1; write = 1'b1; t0 = cyc;
        expect_at(t0 + 2, K_CONF, 8'h00);
        expect_at(t0 + 3, K_CONF, 8'h01);
        expect_at(t0 + 3, K_BUSY, 8'h01);
        expect_at(t0 + 3, K_DATA, 8'hFF);
        expect_at(t0 + 4, K_DATA, 8'hFF);
        step(5);
        read = 1'b0; write = 1'b0; t1 = cyc;
        expect_at(t1 + 2, K_BUSY, 8'h01);
        expect_at(t1 + 3, K_BUSY, 8'h00);
        expect_at(t1 + 4, K_CONF, 8'h01);
        step(5);
        checks++;
        if (ack_cnt != acks0) begin
            errors++;
            $display("FAIL conflict_ack got=%0d exp=0", ack_cnt - acks0);
        end
        read_word(5'h07, 8'h55);
        expect_at(cyc, K_CONF, 8'h01);

        // Reset in the middle of a read
        addr = 5'h01;
        step(1);
        read = 1'b1; t0 = cyc;
        expect_at(t0 + 3, K_DATA, 8'h55);
        step(4);
        rst_n = 1'b0;
        expect_at(cyc, K_DATA, 8'hFF);
        expect_at(cyc, K_BUSY, 8'h00);
        expect_at(cyc, K_CONF, 8'h00);
        read = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        read_word(5'h1F, 8'h00);
        read_word(5'h01, 8'h00);

        step(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
